sync_corr_acc: RTL and testbench

- Parametrised successor to the 2-bit correlator adder tree in the sync IP.
- Sums pDAT_Num signed pIN_W-bit correlator products through a fully pipelined tree with full-precision growth.
- Accumulates a programmable number of consecutive tree results (non-coherent integration over frames), saturates to pOUT_W bits and flags threshold crossings for the sync detector.
- Output valid is aligned to the real pipeline latency.

---
 rtl/sync_corr_acc.sv | 110 +++++++++++
 tb/tb_sync_corr_acc.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sync_corr_acc.sv
// sync_corr_acc: pipelined signed adder tree over pDAT_Num correlator products,
// with saturating multi-frame group accumulation and threshold detection.
module sync_corr_acc #(
  parameter int pIN_W    = 2,
  parameter int pDAT_Num = 1024,
  parameter int pACC_MAX = 16,
  parameter int pOUT_W   = 24
) (
  input  logic                            iclk,
  input  logic                            irst,
  input  logic                            iena,
  input  logic signed [pIN_W-1:0]         idat [0:pDAT_Num-1],
  input  logic [$clog2(pACC_MAX+1)-1:0]   iacc_len,
  input  logic                            iclr,
  input  logic [pOUT_W-1:0]               ithr,
  output logic                            oena,
  output logic signed [pOUT_W-1:0]        odat,
  output logic                            odet,
  output logic                            osat
);
  localparam int L  = $clog2(pDAT_Num);
  localparam int N  = 1 << L;
  localparam int TW = pIN_W + L;
  localparam int LW = $clog2(pACC_MAX + 1);
  localparam int AW = pOUT_W + 1;
  localparam int XW = (TW > pOUT_W ? TW : pOUT_W) + 2;
  localparam logic signed [XW-1:0] MX = {{(XW-pOUT_W+1){1'b0}}, {(pOUT_W-1){1'b1}}};
  localparam logic signed [XW-1:0] MN = ~MX;
  genvar s, i;
  // Each stage grows by one bit; leaves beyond pDAT_Num are tied to zero.
  for (s = 0; s < L; s++) begin : g_st
    localparam int W = pIN_W + s + 1;
    for (i = 0; i < (N >> (s + 1)); i++) begin : g_n
      logic signed [W-2:0] a, b;
      logic signed [W-1:0] r;
      if (s == 0) begin : g_in
        if (2*i < pDAT_Num) begin : g_a
          assign a = idat[2*i];
        end else begin : g_az
          assign a = '0;
        end
        if (2*i + 1 < pDAT_Num) begin : g_b
          assign b = idat[2*i+1];
        end else begin : g_bz
          assign b = '0;
        end
      end else begin : g_up
        assign a = g_st[s-1].g_n[2*i].r;
        assign b = g_st[s-1].g_n[2*i+1].r;
      end
      always_ff @(posedge iclk or posedge irst)
        if (irst) r <= '0;
        else r <= {a[W-2], a} + {b[W-2], b};
    end
  end
  logic signed [TW-1:0] tree;
  logic [L-1:0] vsr;
  logic tv;
  assign tree = g_st[L-1].g_n[0].r;
  assign tv = vsr[L-1];
  logic [LW-1:0] cnt, glen, len_in, gcur, cnt_b;
  logic signed [AW-1:0] acc, sc;
  logic [AW-1:0] mag;
  logic signed [XW-1:0] tx, tc, sx;
  logic sticky, first, tsat, ssat, last, sat_n;
  // A clear in the same cycle as a sample restarts the group on that sample.
  always_comb begin
    len_in = iacc_len == '0 ? LW'(1) : iacc_len > LW'(pACC_MAX) ? LW'(pACC_MAX) : iacc_len;
    first = iclr || cnt == '0;
    cnt_b = first ? '0 : cnt;
    gcur = first ? len_in : glen;
    last = tv && cnt_b == gcur - LW'(1);
    tx = {{(XW-TW){tree[TW-1]}}, tree};
    tsat = tx > MX || tx < MN;
    tc = tsat ? (tx[XW-1] ? MN : MX) : tx;
    sx = (first ? '0 : {{(XW-AW){acc[AW-1]}}, acc}) + tc;
    ssat = sx > MX || sx < MN;
    sc = AW'(ssat ? (sx[XW-1] ? MN : MX) : sx);
    sat_n = (!first && sticky) || tsat || ssat;
    mag = sc[AW-1] ? -sc : sc;
  end
  always_ff @(posedge iclk or posedge irst)
    if (irst) begin
      vsr <= '0;
      cnt <= '0;
      glen <= '0;
      acc <= '0;
      sticky <= 1'b0;
      oena <= 1'b0;
      odat <= '0;
      odet <= 1'b0;
      osat <= 1'b0;
    end else begin
      vsr <= L'({vsr, iena});
      oena <= last;
      odet <= last && mag >= {1'b0, ithr};
      osat <= last && sat_n;
      if (last) odat <= sc[pOUT_W-1:0];
      if (tv) begin
        if (first) glen <= len_in;
        cnt <= last ? '0 : cnt_b + LW'(1);
        acc <= sc;
        sticky <= !last && sat_n;
      end else if (iclr) begin
        cnt <= '0;
        acc <= '0;
        sticky <= 1'b0;
      end
    end
endmodule

// File: tb/tb_sync_corr_acc.sv
// tb_sync_corr_acc: directed bench over three configurations (8 inputs / 24-bit out,
// 5 inputs with zero padding, 8 inputs / 6-bit saturating out) sharing one stimulus.
module tb_sync_corr_acc;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, ena, clr;
  logic [4:0] len;
  logic [23:0] thr;
  logic signed [1:0] d8 [0:7];
  logic signed [1:0] d5 [0:4];
  logic o8_ena, o8_det, o8_sat, o5_ena, o5_det, o5_sat, o6_ena, o6_det, o6_sat;
  logic signed [23:0] o8_dat, o5_dat;
  logic signed [5:0] o6_dat;
  sync_corr_acc #(.pIN_W(2), .pDAT_Num(8), .pACC_MAX(16), .pOUT_W(24)) u8 (
    .iclk(clk), .irst(rst), .iena(ena), .idat(d8), .iacc_len(len), .iclr(clr), .ithr(thr),
    .oena(o8_ena), .odat(o8_dat), .odet(o8_det), .osat(o8_sat));
  sync_corr_acc #(.pIN_W(2), .pDAT_Num(5), .pACC_MAX(16), .pOUT_W(24)) u5 (
    .iclk(clk), .irst(rst), .iena(ena), .idat(d5), .iacc_len(len), .iclr(clr), .ithr(thr),
    .oena(o5_ena), .odat(o5_dat), .odet(o5_det), .osat(o5_sat));
  sync_corr_acc #(.pIN_W(2), .pDAT_Num(8), .pACC_MAX(16), .pOUT_W(6)) u6 (
    .iclk(clk), .irst(rst), .iena(ena), .idat(d8), .iacc_len(len), .iclr(clr), .ithr(thr[5:0]),
    .oena(o6_ena), .odat(o6_dat), .odet(o6_det), .osat(o6_sat));
  typedef struct {int cyc; int dat; bit det; bit sat;} ev_t;
  typedef struct {int a; int b; int g; int thr; int e8; bit d8; int e5;} vec_t;
  ev_t q8[$], q5[$], q6[$];
  vec_t tab[6];
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (o8_ena) q8.push_back('{cyc, o8_dat, o8_det, o8_sat});
    if (o5_ena) q5.push_back('{cyc, o5_dat, o5_det, o5_sat});
    if (o6_ena) q6.push_back('{cyc, o6_dat, o6_det, o6_sat});
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", n, act, exp);
    end
  endtask
  task automatic pat(input int a, input int b);
    for (int i = 0; i < 8; i++) d8[i] = 2'(i % 2 == 0 ? a : b);
    for (int i = 0; i < 5; i++) d5[i] = 2'(i % 2 == 0 ? a : b);
  endtask
  task automatic frames(input int n, output int lc);
    lc = 0;
    for (int k = 0; k < n; k++) begin
      ena = 1'b1;
      lc = cyc;
      tick();
    end
    ena = 1'b0;
  endtask
  task automatic clrq();
    q8.delete();
    q5.delete();
    q6.delete();
  endtask
  function automatic ev_t pick(input int w, input int i);
    ev_t e = '{-1, -9999, 1'b0, 1'b0};
    if (w == 8 && i < q8.size()) e = q8[i];
    if (w == 6 && i < q6.size()) e = q6[i];
    return e;
  endfunction
  task automatic chkev(input string n, input ev_t e, input int c, input int d, input int s);
    chk({n, "_cyc"}, e.cyc, c);
    chk({n, "_dat"}, e.dat, d);
    chk({n, "_sat"}, e.sat, s);
  endtask
  initial begin
    int lc, c0;
    ev_t e;
    tab[0] = '{1, 1, 0, 8, 8, 1'b1, 5};
    tab[1] = '{-2, -2, 1, 16, -16, 1'b1, -10};
    tab[2] = '{1, -1, 1, 0, 0, 1'b1, 1};
    tab[3] = '{-1, 1, 1, 1, 0, 1'b0, -1};
    tab[4] = '{-2, 1, 1, 5, -4, 1'b0, -4};
    tab[5] = '{0, -1, 1, 4, -4, 1'b1, -2};
    rst = 1'b1; ena = 1'b0; clr = 1'b0; len = 5'd1; thr = '0;
    pat(0, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_ena8", o8_ena, 0); chk("rst_dat8", o8_dat, 0);
    chk("rst_det8", o8_det, 0); chk("rst_sat8", o8_sat, 0);
    chk("rst_dat6", o6_dat, 0); chk("rst_dat5", o5_dat, 0);
    for (int k = 0; k < 6; k++) begin
      pat(tab[k].a, tab[k].b);
      len = 5'(tab[k].g);
      thr = 24'(tab[k].thr);
      ena = 1'b1;
      tick();
      ena = 1'b0;
      tick(); tick();
      chk($sformatf("v%0d_early8", k), o8_ena, 0);
      tick();
      chk($sformatf("v%0d_ena8", k), o8_ena, 1);
      chk($sformatf("v%0d_dat8", k), o8_dat, tab[k].e8);
      chk($sformatf("v%0d_det8", k), o8_det, tab[k].d8);
      chk($sformatf("v%0d_sat8", k), o8_sat, 0);
      chk($sformatf("v%0d_ena5", k), o5_ena, 1);
      chk($sformatf("v%0d_dat5", k), o5_dat, tab[k].e5);
      chk($sformatf("v%0d_dat6", k), o6_dat, tab[k].e8);
      chk($sformatf("v%0d_sat6", k), o6_sat, 0);
    end
    tick();
    chk("v_pulse8", o8_ena, 0);
    // Four frames separated by bubbles form one group.
    len = 5'd4; thr = '0; pat(1, 1); clrq();
    lc = 0;
    for (int k = 0; k < 4; k++) begin
      ena = 1'b1; lc = cyc; tick();
      ena = 1'b0; tick();
    end
    repeat (6) tick();
    chk("s1_n8", q8.size(), 1);
    chkev("s1_e8", pick(8, 0), lc + 4, 32, 0);
    chk("s1_n6", q6.size(), 1);
    chkev("s1_e6", pick(6, 0), lc + 4, 31, 1);
    // Two back-to-back groups.
    clrq(); c0 = cyc;
    frames(8, lc);
    repeat (8) tick();
    chk("s2_n8", q8.size(), 2);
    chkev("s2_a8", pick(8, 0), c0 + 7, 32, 0);
    chkev("s2_b8", pick(8, 1), c0 + 11, 32, 0);
    chk("s2_n6", q6.size(), 2);
    chkev("s2_a6", pick(6, 0), c0 + 7, 31, 1);
    chkev("s2_b6", pick(6, 1), c0 + 11, 31, 1);
    clrq(); pat(-2, -2);
    frames(4, lc);
    repeat (8) tick();
    chkev("s3_e6", pick(6, 0), lc + 4, -32, 1);
    chkev("s3_e8", pick(8, 0), lc + 4, -64, 0);
    clrq(); len = 5'd1; pat(1, 1);
    frames(1, lc);
    repeat (6) tick();
    chkev("s4_e6", pick(6, 0), lc + 4, 8, 0);
    // Threshold boundary on a negative sum.
    clrq(); len = 5'd2; pat(-2, -2); thr = 24'd32;
    frames(2, lc);
    repeat (6) tick();
    e = pick(8, 0);
    chkev("s5_e8", e, lc + 4, -32, 0);
    chk("s5_det32", e.det, 1);
    clrq(); thr = 24'd33;
    frames(2, lc);
    repeat (6) tick();
    e = pick(8, 0);
    chkev("s5_f8", e, lc + 4, -32, 0);
    chk("s5_det33", e.det, 0);
    // Clear after two frames have been accumulated.
    clrq(); len = 5'd4; pat(1, 1); thr = '0;
    frames(2, lc);
    repeat (5) tick();
    clr = 1'b1; tick(); clr = 1'b0;
    frames(4, lc);
    repeat (8) tick();
    chk("s6_n8", q8.size(), 1);
    chkev("s6_e8", pick(8, 0), lc + 4, 32, 0);
    // Clear coincident with the second frame's tree output.
    clrq();
    frames(2, lc);
    tick(); tick();
    clr = 1'b1; ena = 1'b1; tick();
    clr = 1'b0; tick();
    lc = cyc; tick();
    ena = 1'b0;
    repeat (8) tick();
    chk("s7_n8", q8.size(), 1);
    chkev("s7_e8", pick(8, 0), lc + 4, 32, 0);
    // Reset with frames in flight.
    clrq(); len = 5'd1;
    frames(2, lc);
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (8) tick();
    chk("s8_n8", q8.size(), 0);
    chk("s8_n5", q5.size(), 0);
    chk("s8_n6", q6.size(), 0);
    chk("s8_dat8", o8_dat, 0);
    chk("s8_dat6", o6_dat, 0);
    frames(1, lc);
    repeat (6) tick();
    chk("s8_post_n8", q8.size(), 1);
    chkev("s8_post8", pick(8, 0), lc + 4, 8, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
